pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline control unit for the five-stage core. It merges per-stage stall requests into the `stall[5:0]` vector consumed by the pc, if_id, id_ex, ex_mem and mem_wb registers. It converts the exception type reported by the mem stage into a `flush` pulse plus the redirect `new_pc`. It also runs a stall watchdog that reports stalls which never release.

## Interface
- `TIMEOUT`, 255: consecutive stalled cycles before `timeout` pulses; legal range 2..65535.
- `INT_VECTOR`, 32'h0000_0020: redirect target for an interrupt.
- `EXC_VECTOR`, 32'h0000_0040: redirect target for syscall, invalid instruction, trap and overflow.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `stallreq_if` in 1: fetch stage (bus or icache) not ready.
- `stallreq_id` in 1: load-use hazard.
- `stallreq_ex` in 1: multi-cycle operation (div, madd) busy.
- `stallreq_mem` in 1: data bus not ready.
- `excepttype_i` in 32: exception code from the mem stage; zero means none.
- `cp0_epc_i` in 32: current EPC, used by eret.
- `stall` out 6: bit 0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb; 1 = `Stop`.
- `flush` out 1: clear all pipeline registers this edge.
- `new_pc` out 32: redirect target; meaningful only while `flush`=1.
- `timeout` out 1: one-cycle pulse on stall-watchdog expiry.

## Operation
- **Stall merge (combinational):**
  - The highest requesting stage k drives `stall[k+1:0]`=1 and all other bits to 0.
  - If maps to 6'b000011, id to 6'b000111, ex to 6'b001111, mem to 6'b011111.
  - With no request, `stall` = 6'b000000.
  - wb never stalls on its own, so `stall[5]` is always 0.
- **FSM states:** RUN, REFILL.
- **RUN:**
  - When `excepttype_i` ≠ 0, `flush`=1 combinationally in the same cycle, `stall` is forced to 0 regardless of requests, and the next state is REFILL.
  - Otherwise `flush`=0.
- **REFILL:**
  - Lasts exactly one cycle. `excepttype_i` is ignored, `flush`=0, stall merge is active.
  - The next state is always RUN.
  - This masks stale codes while pc loads `new_pc`.
- **`new_pc` decode:**
  - 0x1 (interrupt): `INT_VECTOR`.
  - 0x8 (syscall), 0xa (invalid instruction), 0xd (trap), 0xc (overflow): `EXC_VECTOR`.
  - 0xe (eret): `cp0_epc_i`.
  - Any other nonzero code: `EXC_VECTOR`.
  - Zero: 32'h0.
- **Watchdog:**
  - `cnt` increments every cycle in which any stallreq is high and `flush`=0.
  - `cnt` clears to 0 in any cycle with no request or with `flush`=1.
  - When `cnt` reaches TIMEOUT-1 and a request is still high, `timeout` is registered high for one cycle and `cnt` wraps to 0.
  - Counter width is $clog2(TIMEOUT).

## Timing
- **Reset:** `rst` forces state RUN and `cnt` 0. While `rst` is high, `stall`=0, `flush`=0, `new_pc`=0 and `timeout`=0, overriding the inputs.
- **Latency:** `stall`, `flush` and `new_pc` have zero-cycle latency from their inputs. `timeout` rises the cycle after the TIMEOUT-th consecutive stalled cycle.
- **Exception during stall:** `flush` wins. `stall`=0 in the flush cycle and the watchdog clears.
- **Back-to-back exceptions:** a code present in the REFILL cycle is dropped. A code first seen in the following RUN cycle is taken.
- **Reset mid-REFILL:** the next state is RUN with no `flush` emitted.
- **Continuous stall:** `timeout` repeats every TIMEOUT cycles for as long as the stall persists.

## Structure
- Exception codes (0x1, 0x8, 0xa, 0xc, 0xd, 0xe), `Stop`/`NoStop`, `ZeroWord` and the FSM state encodings live in `defines.v`.
- One sub-module, `stall_watchdog` (parameter `TIMEOUT`), holds the counter and the `timeout` register. The FSM, stall merge and `new_pc` decode stay in `pipe_ctrl`.

## Test plan
- **Reset and idle:** hold `rst` 3 cycles with all stallreq=1 and `excepttype_i`=0x8, then release with all inputs at 0 → all outputs 0 throughout; `stall`=6'b000000 after release.
- **Stall merge:**
  - `stallreq_ex`=1 alone → `stall`=6'b001111.
  - `stallreq_id`=1 and `stallreq_mem`=1 → `stall`=6'b011111.
  - `stallreq_if` alone → `stall`=6'b000011.
- **Exception over stall:** `stallreq_ex`=1 with `excepttype_i`=0x8 → same cycle `flush`=1, `stall`=0, `new_pc`=0x40. Next cycle `flush`=0 and `stall`=6'b001111.
- **eret then masked repeat:**
  - `excepttype_i`=0xe, `cp0_epc_i`=0x0000_1234 → `new_pc`=0x1234, `flush`=1.
  - Holding 0xe into the next cycle → `flush`=0.
  - Holding it a third cycle → `flush`=1 again.
- **Watchdog, TIMEOUT=4:** `stallreq_if` held 9 cycles → `timeout` pulses one cycle after stalled cycles 4 and 8.
  - Variant: drop the request after 3 cycles, then hold it again for 4 → exactly one pulse, timed from the restart.
- **Interrupt and reset mid-REFILL:** `excepttype_i`=0x1 → `new_pc`=0x20. Assert `rst` in the REFILL cycle, then apply 0xc → `flush`=1, `new_pc`=0x40.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit: exception codes,
// stall encodings, FSM states and the stall-merge helper.
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_REFILL = 1'b1
  } state_e;

  localparam logic        STOP      = 1'b1;
  localparam logic        NOSTOP    = 1'b0;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  localparam logic [31:0] EXC_INT      = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL  = 32'h0000_0008;
  localparam logic [31:0] EXC_INVALID  = 32'h0000_000a;
  localparam logic [31:0] EXC_OVERFLOW = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP     = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET     = 32'h0000_000e;

  // The highest requesting stage freezes itself and everything upstream of it.
  function automatic logic [5:0] stall_merge(input logic rq_if, input logic rq_id,
                                             input logic rq_ex, input logic rq_mem);
    logic [5:0] m;
    m = {6{NOSTOP}};
    if (rq_mem) begin
      m = {NOSTOP, {5{STOP}}};
    end else if (rq_ex) begin
      m = {{2{NOSTOP}}, {4{STOP}}};
    end else if (rq_id) begin
      m = {{3{NOSTOP}}, {3{STOP}}};
    end else if (rq_if) begin
      m = {{4{NOSTOP}}, {2{STOP}}};
    end else begin
      m = {6{NOSTOP}};
    end
    return m;
  endfunction

endpackage

// File: rtl/pipe_ctrl_watchdog.sv
// Stall watchdog: counts consecutive stalled cycles and pulses timeout
// once every TIMEOUT cycles while a stall persists.
module stall_watchdog
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic req_any,
  input  logic flush,
  output logic timeout
);

  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_r;
  logic          timeout_r;

  // Count stalled cycles; any gap or flush restarts the run, expiry wraps to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r     <= '0;
      timeout_r <= 1'b0;
    end else if (!req_any || flush) begin
      cnt_r     <= '0;
      timeout_r <= 1'b0;
    end else if (cnt_r == LAST_CNT) begin
      cnt_r     <= '0;
      timeout_r <= 1'b1;
    end else begin
      cnt_r     <= cnt_r + CW'(1);
      timeout_r <= 1'b0;
    end
  end

  // Reset overrides a pulse that is still sitting in the register.
  assign timeout = timeout_r & ~rst;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: stall merge, exception flush/redirect FSM and
// stall watchdog for the five-stage core.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT    = 255,
  parameter logic [31:0] INT_VECTOR = 32'h0000_0020,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0040
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        timeout
);

  state_e      state_r;
  logic        req_any_s;
  logic        flush_s;
  logic [5:0]  stall_s;
  logic [31:0] new_pc_s;

  function automatic logic [31:0] decode_pc(input logic [31:0] code, input logic [31:0] epc);
    logic [31:0] pc;
    case (code)
      ZERO_WORD:    pc = ZERO_WORD;
      EXC_INT:      pc = INT_VECTOR;
      EXC_SYSCALL,
      EXC_INVALID,
      EXC_TRAP,
      EXC_OVERFLOW: pc = EXC_VECTOR;
      EXC_ERET:     pc = epc;
      default:      pc = EXC_VECTOR;
    endcase
    return pc;
  endfunction

  assign req_any_s = stallreq_if | stallreq_id | stallreq_ex | stallreq_mem;

  // Same-cycle flush/stall/redirect; an exception taken in RUN beats any stall.
  always_comb begin
    flush_s  = 1'b0;
    stall_s  = {6{NOSTOP}};
    new_pc_s = ZERO_WORD;
    if (rst) begin
      flush_s  = 1'b0;
      stall_s  = {6{NOSTOP}};
      new_pc_s = ZERO_WORD;
    end else if ((state_r == ST_RUN) && (excepttype_i != ZERO_WORD)) begin
      flush_s  = 1'b1;
      stall_s  = {6{NOSTOP}};
      new_pc_s = decode_pc(excepttype_i, cp0_epc_i);
    end else begin
      flush_s  = 1'b0;
      stall_s  = stall_merge(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
      new_pc_s = ZERO_WORD;
    end
  end

  // After a flush spend one REFILL cycle ignoring the stale exception code.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_RUN;
    end else begin
      case (state_r)
        ST_RUN:    state_r <= flush_s ? ST_REFILL : ST_RUN;
        ST_REFILL: state_r <= ST_RUN;
        default:   state_r <= ST_RUN;
      endcase
    end
  end

  stall_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .req_any (req_any_s),
    .flush   (flush_s),
    .timeout (timeout)
  );

  assign stall  = stall_s;
  assign flush  = flush_s;
  assign new_pc = new_pc_s;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios followed by random
// stimulus, all compared against a cycle-level behavioural model.
module tb_pipe_ctrl;

  localparam int unsigned TO = 4;

  logic        clk;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic [31:0] excepttype_i, cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  bit m_masked = 1'b0;   // previous cycle flushed, so this cycle ignores codes
  int m_run    = 0;      // consecutive stalled cycles since last clear
  bit m_to     = 1'b0;   // timeout expected this cycle

  pipe_ctrl #(
    .TIMEOUT    (TO),
    .INT_VECTOR (32'h0000_0020),
    .EXC_VECTOR (32'h0000_0040)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_if  (stallreq_if),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .excepttype_i (excepttype_i),
    .cp0_epc_i    (cp0_epc_i),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .timeout      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_pc(input logic [31:0] code, input logic [31:0] epc);
    if (code == 32'h0)      return 32'h0;
    else if (code == 32'h1) return 32'h20;
    else if (code == 32'he) return epc;
    else                    return 32'h40;
  endfunction

  // One clock cycle: apply inputs, check outputs mid-cycle, advance the model.
  task automatic cyc(input bit r, input bit qi, input bit qd, input bit qe, input bit qm,
                     input logic [31:0] exc, input logic [31:0] epc);
    int k;
    bit any;
    bit exp_flush;
    logic [5:0] exp_stall;
    logic [31:0] exp_pc;
    @(negedge clk);
    rst = r; stallreq_if = qi; stallreq_id = qd; stallreq_ex = qe; stallreq_mem = qm;
    excepttype_i = exc; cp0_epc_i = epc;
    #2;
    any = qi | qd | qe | qm;
    k = qm ? 3 : qe ? 2 : qd ? 1 : qi ? 0 : -1;
    exp_flush = !r && !m_masked && (exc != 32'h0);
    if (r || exp_flush || k < 0) exp_stall = 6'b0;
    else exp_stall = 6'((1 << (k + 2)) - 1);
    exp_pc = exp_flush ? ref_pc(exc, epc) : 32'h0;
    chk("stall", {26'b0, stall}, {26'b0, exp_stall});
    chk("flush", {31'b0, flush}, {31'b0, exp_flush});
    if (r || exp_flush) chk("new_pc", new_pc, exp_pc);
    chk("timeout", {31'b0, timeout}, {31'b0, (m_to && !r)});
    if (r) begin
      m_masked = 1'b0; m_run = 0; m_to = 1'b0;
    end else begin
      m_masked = exp_flush;
      m_to = 1'b0;
      if (any && !exp_flush) begin
        m_run++;
        if (m_run == int'(TO)) begin
          m_to = 1'b1;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] codes [8];
    logic [31:0] exc;
    codes[0] = 32'h1; codes[1] = 32'h8; codes[2] = 32'ha; codes[3] = 32'hc;
    codes[4] = 32'hd; codes[5] = 32'he; codes[6] = 32'h1f; codes[7] = 32'h200;
    rst = 1'b1; stallreq_if = 1'b0; stallreq_id = 1'b0; stallreq_ex = 1'b0;
    stallreq_mem = 1'b0; excepttype_i = 32'h0; cp0_epc_i = 32'h0;

    // reset with everything asserted
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h8, 32'h0);
    idle(2);

    // stall merge patterns
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(2);

    // exception over stall, then stall returns in REFILL
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    idle(2);

    // eret held three cycles: taken, masked, taken
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'he, 32'h0000_1234);
    idle(2);

    // watchdog: nine stalled cycles give two pulses
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(2);
    // watchdog restart: 3 cycles, gap, 4 cycles
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(2);

    // interrupt, reset during REFILL, then overflow taken
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hc, 32'h0);
    idle(2);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) exc = codes[$urandom_range(0, 7)];
      else exc = 32'h0;
      cyc(($urandom_range(0, 49) == 0),
          ($urandom_range(0, 2) != 0), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 6) == 0), ($urandom_range(0, 7) == 0),
          exc, $urandom);
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
